// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity
// (enabled by defining PARITY_CHECK_EN), stop bit; word is presented with valid/ready.
module sipo_frame_rx #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shifter;
  logic             parity_ok;

`ifdef PARITY_CHECK_EN
  logic par_bit;
  // Even parity: data bits plus parity bit hold an even number of ones.
  assign parity_ok = ~^{shifter, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // later assignments in the same block override earlier ones on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shifter    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (si_en) begin
        case (state)
          IDLE: begin
            if (si) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            // Right shift: after WIDTH bits the first bit received sits at bit 0.
            shifter <= {si, shifter[WIDTH-1:1]};
            if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            par_bit <= si;
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (si || !parity_ok) begin
              frame_err <= 1'b1;
            end else if (!dout_valid || dout_ready) begin
              // Overrides the handshake clear above when a word lands on the consume edge.
              dout       <= shifter;
              dout_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed frames followed by randomized frames,
// checked against a frame-level model of the expected parallel outputs.
module tb_sipo_frame_rx;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             si;
  logic             si_en;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             frame_err;
  logic             overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_dout;
  logic             exp_valid;
  logic             exp_ovf;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .si_en      (si_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_ferr);
    check({tag, ".dout"},       dout,       exp_dout);
    check({tag, ".dout_valid"}, dout_valid, exp_valid);
    check({tag, ".frame_err"},  frame_err,  exp_ferr);
    check({tag, ".overflow"},   overflow,   exp_ovf);
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are read at the same point.
  task automatic tick(input logic b, input logic en, input logic rdy);
    si         = b;
    si_en      = en;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick(1'b1, 1'b1, 1'b0);
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    check_outs("reset", 1'b0);
    rst = 1'b0;
  endtask

  task automatic consume();
    tick(1'b0, 1'($urandom), 1'b1);
    exp_valid = 1'b0;
    check_outs("consume", 1'b0);
  endtask

  // gap_mode: 0 none, 1 one idle strobe after each bit, 2 random 0..2.
  // ready_mode: 0 ready low, 1 ready high throughout, 2 ready high only on the stop-bit clock.
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit,
                            input logic par_flip, input int gap_mode, input int ready_mode);
    logic bits[$];
    logic good;
    logic rdy;
    bits.push_back(1'b1);
    for (int i = 0; i < WIDTH; i++) bits.push_back(data[i]);
`ifdef PARITY_CHECK_EN
    bits.push_back((^data) ^ par_flip);
    good = !stop_bit && !par_flip;
`else
    good = !stop_bit;
`endif
    bits.push_back(stop_bit);

    for (int k = 0; k < bits.size(); k++) begin
      if (k < bits.size() - 1) begin
        rdy = (ready_mode == 1);
        tick(bits[k], 1'b1, rdy);
        if (rdy) exp_valid = 1'b0;
        check_outs("bit", 1'b0);
        begin
          int n;
          n = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
          for (int j = 0; j < n; j++) begin
            tick(1'($urandom), 1'b0, rdy);
            check_outs("gap", 1'b0);
          end
        end
      end else begin
        rdy = (ready_mode != 0);
        tick(bits[k], 1'b1, rdy);
        if (good) begin
          if (!exp_valid || rdy) begin
            exp_dout  = data;
            exp_valid = 1'b1;
          end else begin
            exp_ovf = 1'b1;
          end
        end else if (rdy) begin
          exp_valid = 1'b0;
        end
        check_outs("stop", !good);
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst        = 1'b0;
    si         = 1'b0;
    si_en      = 1'b0;
    dout_ready = 1'b0;
    exp_dout   = '0;
    exp_valid  = 1'b0;
    exp_ovf    = 1'b0;

    // Reset with the line held at start level: nothing may be detected.
    do_reset(2);
    tick(1'b0, 1'b1, 1'b0);
    check_outs("idle", 1'b0);

    // Serial 1,1,0,0,1,1,0 -> 5'b11001, then consume.
    send_frame(5'b11001, 1'b0, 1'b0, 0, 0);
    consume();

    // Strobe alternating with idle clocks.
    send_frame(5'b10101, 1'b0, 1'b0, 1, 0);
    consume();

    // Bad stop bit, then a good frame back-to-back.
    send_frame(5'b01101, 1'b1, 1'b0, 0, 0);
    send_frame(5'b10010, 1'b0, 1'b0, 0, 0);
    consume();

    // New word completing on the consume edge: reload, no overflow.
    send_frame(5'b00011, 1'b0, 1'b0, 0, 0);
    send_frame(5'b11100, 1'b0, 1'b0, 2, 2);
    consume();

    // Two frames back-to-back with ready low: second word dropped, overflow sticky.
    send_frame(5'b01010, 1'b0, 1'b0, 0, 0);
    send_frame(5'b10111, 1'b0, 1'b0, 0, 0);
    consume();
    tick(1'b0, 1'b1, 1'b0);
    check_outs("sticky", 1'b0);

    // Reset in the middle of a frame, then a clean frame.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    do_reset(1);
    send_frame(5'b00111, 1'b0, 1'b0, 0, 0);
`ifdef PARITY_CHECK_EN
    consume();
    send_frame(5'b00111, 1'b0, 1'b1, 0, 0);
    send_frame(5'b00111, 1'b0, 1'b0, 0, 0);
`endif
    consume();

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      w = WIDTH'($urandom);
      send_frame(w, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
